// File: rtl/fastica_mul_transpose.sv
// Transpose matrix-vector product z = W^T * y using one shared signed multiplier, 16 MAC cycles.
// Optional macro FASTICA_MULT_SAT_EN saturates each result instead of wrapping it to DW bits.
module fastica_mul_transpose #(
    parameter int unsigned DW        = 26,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                 clk_mul,
    input  logic                 rstn_mul,
    input  logic                 en_mul,
    input  logic                 start,
    input  logic signed [DW-1:0] w11,
    input  logic signed [DW-1:0] w12,
    input  logic signed [DW-1:0] w13,
    input  logic signed [DW-1:0] w14,
    input  logic signed [DW-1:0] w21,
    input  logic signed [DW-1:0] w22,
    input  logic signed [DW-1:0] w23,
    input  logic signed [DW-1:0] w24,
    input  logic signed [DW-1:0] w31,
    input  logic signed [DW-1:0] w32,
    input  logic signed [DW-1:0] w33,
    input  logic signed [DW-1:0] w34,
    input  logic signed [DW-1:0] w41,
    input  logic signed [DW-1:0] w42,
    input  logic signed [DW-1:0] w43,
    input  logic signed [DW-1:0] w44,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] y2,
    input  logic signed [DW-1:0] y3,
    input  logic signed [DW-1:0] y4,
    output logic signed [DW-1:0] z1,
    output logic signed [DW-1:0] z2,
    output logic signed [DW-1:0] z3,
    output logic signed [DW-1:0] z4,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned AW = 2 * DW + 2;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [DW-1:0]  w_q   [16];
    logic signed [DW-1:0]  y_q   [4];
    logic signed [DW-1:0]  res_q [4];
    logic                  busy_q;
    logic                  done_q;

    logic signed [DW-1:0]  w_in [16];
    logic signed [DW-1:0]  y_in [4];

    // Row-major: w_in[(row-1)*4 + (col-1)]
    assign w_in[0]  = w11;
    assign w_in[1]  = w12;
    assign w_in[2]  = w13;
    assign w_in[3]  = w14;
    assign w_in[4]  = w21;
    assign w_in[5]  = w22;
    assign w_in[6]  = w23;
    assign w_in[7]  = w24;
    assign w_in[8]  = w31;
    assign w_in[9]  = w32;
    assign w_in[10] = w33;
    assign w_in[11] = w34;
    assign w_in[12] = w41;
    assign w_in[13] = w42;
    assign w_in[14] = w43;
    assign w_in[15] = w44;
    assign y_in[0]  = y1;
    assign y_in[1]  = y2;
    assign y_in[2]  = y3;
    assign y_in[3]  = y4;

    logic signed [DW-1:0]   mul_a;
    logic signed [DW-1:0]   mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   shifted;
    logic signed [DW-1:0]   reduced;

    // cnt[3:2] selects output column i, cnt[1:0] selects row j: operand is w(j)(i) * y(j)
    assign mul_a   = w_q[{cnt_q[1:0], cnt_q[3:2]}];
    assign mul_b   = y_q[cnt_q[1:0]];
    assign prod    = mul_a * mul_b;
    assign sum     = acc_q + AW'(prod);
    assign shifted = sum >>> FRAC_BITS;

`ifdef FASTICA_MULT_SAT_EN
    logic ovf_pos;
    logic ovf_neg;

    // Value fits in DW bits only when all bits from DW-1 upward equal the sign bit
    assign ovf_pos = !shifted[AW-1] && (|shifted[AW-2:DW-1]);
    assign ovf_neg = shifted[AW-1] && !(&shifted[AW-2:DW-1]);

    always_comb begin
        reduced = shifted[DW-1:0];
        if (ovf_pos) begin
            reduced = {1'b0, {(DW-1){1'b1}}};
        end else if (ovf_neg) begin
            reduced = {1'b1, {(DW-1){1'b0}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[AW-1:DW];
    assign reduced   = shifted[DW-1:0];
`endif

    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z1      <= '0;
            z2      <= '0;
            z3      <= '0;
            z4      <= '0;
            for (int k = 0; k < 16; k++) begin
                w_q[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                y_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else if (en_mul) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k < 16; k++) begin
                            w_q[k] <= w_in[k];
                        end
                        for (int k = 0; k < 4; k++) begin
                            y_q[k] <= y_in[k];
                        end
                        acc_q   <= '0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        res_q[cnt_q[3:2]] <= reduced;
                        acc_q             <= '0;
                    end else begin
                        acc_q <= sum;
                    end
                    if (cnt_q == 4'd15) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    z1      <= res_q[0];
                    z2      <= res_q[1];
                    z3      <= res_q[2];
                    z4      <= res_q[3];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fastica_mul_transpose.sv
// Self-checking bench for fastica_mul_transpose: directed table, timing corner cases, random vs model.
module tb_fastica_mul_transpose;

    localparam int DW        = 26;
    localparam int FRAC_BITS = 0;

    typedef struct packed {
        logic [15:0][DW-1:0] w;
        logic [3:0][DW-1:0]  y;
        logic [3:0][DW-1:0]  z;
    } vec_t;

    logic                 clk;
    logic                 rstn;
    logic                 en;
    logic                 start;
    logic signed [DW-1:0] w_drv [16];
    logic signed [DW-1:0] y_drv [4];
    logic signed [DW-1:0] z_out [4];
    logic                 busy;
    logic                 done;

    int n_vec;
    int n_fail;

    fastica_mul_transpose dut (
        .clk_mul  (clk),
        .rstn_mul (rstn),
        .en_mul   (en),
        .start    (start),
        .w11      (w_drv[0]),
        .w12      (w_drv[1]),
        .w13      (w_drv[2]),
        .w14      (w_drv[3]),
        .w21      (w_drv[4]),
        .w22      (w_drv[5]),
        .w23      (w_drv[6]),
        .w24      (w_drv[7]),
        .w31      (w_drv[8]),
        .w32      (w_drv[9]),
        .w33      (w_drv[10]),
        .w34      (w_drv[11]),
        .w41      (w_drv[12]),
        .w42      (w_drv[13]),
        .w43      (w_drv[14]),
        .w44      (w_drv[15]),
        .y1       (y_drv[0]),
        .y2       (y_drv[1]),
        .y3       (y_drv[2]),
        .y4       (y_drv[3]),
        .z1       (z_out[0]),
        .z2       (z_out[1]),
        .z3       (z_out[2]),
        .z4       (z_out[3]),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_z(input string name, input logic signed [DW-1:0] act,
                           input logic signed [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 16; i++) w_drv[i] = v.w[i];
        for (int i = 0; i < 4; i++) y_drv[i] = v.y[i];
    endtask

    // Reference: z_i = sum_j W[j][i] * y[j], then shift and reduce to DW bits
    task automatic model(output logic [3:0][DW-1:0] ez);
        longint s;
        longint lo;
        longint hi;
        lo = -(longint'(1) <<< (DW - 1));
        hi = (longint'(1) <<< (DW - 1)) - 1;
        for (int i = 0; i < 4; i++) begin
            s = 0;
            for (int j = 0; j < 4; j++) begin
                s += longint'(w_drv[j*4+i]) * longint'(y_drv[j]);
            end
            s = s >>> FRAC_BITS;
`ifdef FASTICA_MULT_SAT_EN
            if (s > hi) s = hi;
            if (s < lo) s = lo;
`endif
            ez[i] = s[DW-1:0];
        end
    endtask

    // mode 0: plain; mode 1: disturb inputs and re-pulse start at cycles 3 and 8;
    // mode 2: clock enable low for edges 6..10
    task automatic run_op(input string name, input logic [3:0][DW-1:0] ez,
                          input int exp_lat, input int mode);
        int lat;
        int dones;
        logic signed [DW-1:0] e;
        lat   = -1;
        dones = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            start = (mode == 1) && (k == 3 || k == 8);
            if (start) begin
                y_drv[0] = y_drv[0] + DW'(11);
                w_drv[0] = ~w_drv[0];
            end
            en = (mode == 2) ? !(k >= 6 && k <= 10) : 1'b1;
            step();
            if (k == 1) check_i({name, " busy_run"}, int'(busy), 1);
            if (done) begin
                dones++;
                if (lat < 0) lat = k;
            end
            if (lat > 0 && !(mode == 1 && k < 25)) break;
        end
        start = 1'b0;
        en    = 1'b1;
        check_i({name, " latency"}, lat, exp_lat);
        if (mode == 1) check_i({name, " done_count"}, dones, 1);
        for (int i = 0; i < 4; i++) begin
            e = ez[i];
            check_z($sformatf("%s z%0d", name, i + 1), z_out[i], e);
        end
        check_i({name, " busy_after"}, int'(busy), 0);
    endtask

    vec_t tbl [5];
    logic [3:0][DW-1:0] ez;

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rstn   = 1'b0;
        en     = 1'b1;
        start  = 1'b1;
        for (int i = 0; i < 16; i++) w_drv[i] = '0;
        for (int i = 0; i < 4; i++) y_drv[i] = '0;

        for (int i = 0; i < 5; i++) tbl[i] = '0;
        // identity, y=(1,2,3,4)
        for (int i = 0; i < 4; i++) begin
            tbl[0].w[i*5] = DW'(1);
            tbl[0].y[i]   = DW'(i + 1);
            tbl[0].z[i]   = DW'(i + 1);
        end
        // transpose indexing: w12=5, w43=-3
        tbl[1].w[1]  = DW'(5);
        tbl[1].w[14] = DW'(-3);
        tbl[1].y[0]  = DW'(7);
        tbl[1].y[3]  = DW'(2);
        tbl[1].z[1]  = DW'(35);
        tbl[1].z[2]  = DW'(-6);
        // overflow: 2^24 * 2^24
        tbl[2].w[0] = DW'(32'd16777216);
        tbl[2].y[0] = DW'(32'd16777216);
`ifdef FASTICA_MULT_SAT_EN
        tbl[2].z[0] = DW'(32'd33554431);
`else
        tbl[2].z[0] = '0;
`endif
        // all -1, ones
        for (int i = 0; i < 16; i++) tbl[3].w[i] = DW'(-1);
        for (int i = 0; i < 4; i++) begin
            tbl[3].y[i] = DW'(1);
            tbl[3].z[i] = DW'(-4);
        end
        // w(r)(c) = 10r + c, y=(1,2,3,4): z_c = 300 + 10c
        for (int r = 1; r <= 4; r++) begin
            for (int c = 1; c <= 4; c++) tbl[4].w[(r-1)*4+(c-1)] = DW'(10 * r + c);
        end
        for (int i = 0; i < 4; i++) begin
            tbl[4].y[i] = DW'(i + 1);
            tbl[4].z[i] = DW'(310 + 10 * i);
        end

        // reset holds everything at zero even with start and enable high
        step();
        step();
        check_i("reset busy", int'(busy), 0);
        check_i("reset done", int'(done), 0);
        for (int i = 0; i < 4; i++) check_z($sformatf("reset z%0d", i + 1), z_out[i], '0);
        start = 1'b0;
        rstn  = 1'b1;
        step();
        check_i("idle busy", int'(busy), 0);

        for (int n = 0; n < 5; n++) begin
            load(tbl[n]);
            run_op($sformatf("tbl%0d", n), tbl[n].z, 17, 0);
        end

        // back-to-back: start while done is high
        check_i("b2b done_high", int'(done), 1);
        load(tbl[1]);
        run_op("busy_ignore", tbl[1].z, 17, 1);

        load(tbl[4]);
        run_op("en_stall", tbl[4].z, 22, 2);

        // done holds while disabled, clears on next enabled edge
        en = 1'b0;
        step();
        step();
        check_i("done_hold", int'(done), 1);
        en = 1'b1;
        step();
        check_i("done_clear", int'(done), 0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) w_drv[i] = DW'($urandom);
                else w_drv[i] = DW'(int'($urandom_range(0, 400)) - 200);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) y_drv[i] = DW'($urandom);
                else y_drv[i] = DW'(int'($urandom_range(0, 400)) - 200);
            end
            model(ez);
            run_op($sformatf("rand%0d", n), ez, 17, 0);
        end

        // reset mid-operation at edge 9
        load(tbl[0]);
        run_op("pre_abort", tbl[0].z, 17, 0);
        load(tbl[4]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        rstn = 1'b0;
        #1;
        check_i("abort busy", int'(busy), 0);
        check_i("abort done", int'(done), 0);
        for (int i = 0; i < 4; i++) check_z($sformatf("abort z%0d", i + 1), z_out[i], '0);
        step();
        step();
        check_i("abort done_held", int'(done), 0);
        rstn = 1'b1;
        step();
        check_i("post_abort done", int'(done), 0);
        run_op("after_abort", tbl[4].z, 17, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
